// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the multi-channel SPI ADC receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_e;

  // Bits needed to hold values 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_ok(input int width, input int total, input int lead,
                                   input int clk_div, input int quiet, input int channels);
    return (width >= 1) && (lead >= 0) && (lead + width <= total) &&
           (clk_div >= 1) && (quiet >= 1) && (channels >= 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: sclk idles low, toggles every CLK_DIV cycles while enabled, and
// flags the cycle whose closing edge makes sclk rise or fall.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = en && (div_cnt == DIV_END);
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_adc_rx_multi.sv
// Multi-channel SPI ADC capture: generates SCLK/CS_n, shifts CHANNELS MISO lines
// in parallel and publishes all samples together once per frame.
module spi_adc_rx_multi
  import spi_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 10,
  parameter int TOTAL_BITS   = 14,
  parameter int LEAD_BITS    = 2,
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      start,
  input  logic                      cont_en,
  input  logic [CHANNELS-1:0]       miso,
  output logic                      sclk,
  output logic                      cs_n,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      overrun
);

  if (!params_ok(WIDTH, TOTAL_BITS, LEAD_BITS, CLK_DIV, QUIET_CYCLES, CHANNELS)) begin : g_bad_params
    $error("spi_adc_rx_multi: illegal parameter combination");
  end

  localparam int CNT_W = cnt_w(max2(CLK_DIV, QUIET_CYCLES));
  localparam int BIT_W = cnt_w(TOTAL_BITS + 1);

  localparam logic [CNT_W-1:0] SETUP_END  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [BIT_W-1:0] FIRST_KEEP = BIT_W'(LEAD_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_KEEP  = BIT_W'(LEAD_BITS + WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(TOTAL_BITS);

  state_e                       state;
  logic [CNT_W-1:0]             cnt;
  logic [BIT_W-1:0]             bit_cnt;
  logic                         single;
  logic                         sclk_rise;
  logic                         sclk_fall;
  logic                         shift_en;
  logic [CHANNELS-1:0][WIDTH-1:0] shreg;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk     (clk),
    .reset_b (reset_b),
    .en      (state == ST_SHIFT),
    .sclk    (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // bit_cnt advances on each rising edge, so at a falling edge it names the bit
  // being sampled (1-based); only the window after the lead bits is kept.
  assign shift_en = (state == ST_SHIFT) && sclk_fall &&
                    (bit_cnt >= FIRST_KEEP) && (bit_cnt <= LAST_KEEP);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] sr;
    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)      sr <= '0;
      else if (shift_en) sr <= (sr << 1) | WIDTH'(miso[i]);
    end
    assign shreg[i] = sr;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= ST_IDLE;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      single     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      overrun    <= start && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (start || cont_en) begin
            state   <= ST_CS_SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            single  <= start && cont_en;
          end
        end
        ST_CS_SETUP: begin
          if (cnt == SETUP_END) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) bit_cnt <= bit_cnt + BIT_W'(1);
          if (sclk_fall && (bit_cnt == LAST_BIT)) begin
            state <= ST_CS_HOLD;
            cs_n  <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_CS_HOLD: begin
          // All channels publish together on the first quiet cycle.
          if (cnt == '0) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
          end
          if (cnt == HOLD_END) begin
            if (cont_en && !single) begin
              state   <= ST_CS_SETUP;
              cs_n    <= 1'b0;
              cnt     <= '0;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_rx_multi.sv
// Self-checking bench: ADC models drive MISO per frame, expected samples come from
// slicing each frame's bit string; timing is checked against frame-start edges.
module tb_spi_adc_rx_multi;
  localparam int CH  = 4;
  localparam int W   = 10;
  localparam int TOT = 14;
  localparam int LB  = 2;
  localparam int SHR = TOT - LB - W;

  typedef logic [CH-1:0][TOT-1:0] frame_t;
  typedef logic [CH*W-1:0]        data_t;

  logic          clk = 1'b0, reset_b = 1'b0, start = 1'b0, cont_en = 1'b0;
  logic [CH-1:0] miso = '0;
  logic          sclk, cs_n, data_valid, busy, overrun;
  data_t         data_out;

  logic          start2 = 1'b0;
  logic [0:0]    miso2 = '0;
  logic          sclk2, cs_n2, data_valid2, busy2, overrun2;
  logic [11:0]   data_out2;

  int total = 0, bad = 0, cyc = 0;

  frame_t frame_q[$];
  frame_t started_q[$];
  data_t  vq[$];
  int     vc[$], oc[$];
  int     rises = 0, cs_fall = 0, cs_rise = 0;
  logic   sclk_d = 1'b0, cs_d = 1'b1;
  logic [15:0] frame2 = '0;
  logic [11:0] vq2[$];
  int          vc2[$];

  spi_adc_rx_multi dut (
    .clk(clk), .reset_b(reset_b), .start(start), .cont_en(cont_en), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .overrun(overrun)
  );

  spi_adc_rx_multi #(.CHANNELS(1), .WIDTH(12), .TOTAL_BITS(16), .LEAD_BITS(4),
                     .CLK_DIV(1), .QUIET_CYCLES(4)) dut2 (
    .clk(clk), .reset_b(reset_b), .start(start2), .cont_en(1'b0), .miso(miso2),
    .sclk(sclk2), .cs_n(cs_n2), .data_out(data_out2), .data_valid(data_valid2),
    .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic data_t model(input frame_t f);
    data_t d = '0;
    for (int c = 0; c < CH; c++) d[c*W +: W] = W'(f[c] >> SHR);
    return d;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int c = 0; c < CH; c++) f[c] = TOT'($urandom);
    return f;
  endfunction

  // ADC model: first bit valid once CS_n falls, next bit after each SCLK fall.
  frame_t cur;
  int     bidx = 0, fidx = 0;
  bit     in_frame = 1'b0;
  always begin
    @(cs_n or negedge sclk);
    #1;
    if (cs_n) in_frame = 1'b0;
    else if (!in_frame) begin
      in_frame = 1'b1;
      bidx = 0;
      if (fidx < frame_q.size()) begin cur = frame_q[fidx]; fidx++; end
      else cur = rand_frame();
      started_q.push_back(cur);
    end else bidx++;
    for (int c = 0; c < CH; c++) miso[c] = (!cs_n && bidx < TOT) ? cur[c][TOT-1-bidx] : 1'b0;
  end

  logic [15:0] cur2;
  int          bidx2 = 0;
  bit          in2 = 1'b0;
  always begin
    @(cs_n2 or negedge sclk2);
    #1;
    if (cs_n2) in2 = 1'b0;
    else if (!in2) begin in2 = 1'b1; bidx2 = 0; cur2 = frame2; end
    else bidx2++;
    miso2[0] = (!cs_n2 && bidx2 < 16) ? cur2[15-bidx2] : 1'b0;
  end

  always @(negedge clk) begin
    if (data_valid)  begin vq.push_back(data_out);   vc.push_back(cyc);  end
    if (data_valid2) begin vq2.push_back(data_out2); vc2.push_back(cyc); end
    if (overrun) oc.push_back(cyc);
    if (sclk && !sclk_d) rises <= rises + 1;
    if (!cs_n && cs_d) cs_fall <= cyc;
    if (cs_n && !cs_d) cs_rise <= cyc;
    sclk_d <= sclk;
    cs_d   <= cs_n;
  end

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
    total++; if ({data_valid, busy, overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {data_valid, busy, overrun}); end
    total++; if ({cs_n2, sclk2, data_out2} !== {1'b1, 1'b0, 12'h000}) begin bad++; $display("FAIL reset_dut2 got=%b%b%h", cs_n2, sclk2, data_out2); end
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({cs_n, busy} !== 2'b10) begin bad++; $display("FAIL reset_release got=%b want=10", {cs_n, busy}); end
  endtask

  task automatic test_single();
    int vals[CH] = '{'h2AA, 'h155, 'h3FF, 'h001};
    frame_t f;
    int n0, r0, e0;
    for (int c = 0; c < CH; c++) f[c] = TOT'(vals[c]) << SHR;
    frame_q.push_back(f);
    n0 = vq.size(); r0 = rises;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 e0 = cyc; start = 1'b0;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b want=0", busy); end
    total++; if (vq.size() - n0 != 1) begin bad++; $display("FAIL single_count got=%0d want=1", vq.size() - n0); end
    if (vq.size() > n0) begin
      total++; if (vq[n0] !== model(f)) begin bad++; $display("FAIL single_data got=%h want=%h", vq[n0], model(f)); end
      total++; if (vc[n0] != e0 + 59) begin bad++; $display("FAIL single_valid_time got=%0d want=%0d", vc[n0] - e0, 59); end
    end
    total++; if (cs_rise - cs_fall != 58 || cs_fall != e0) begin bad++; $display("FAIL single_cs_low got=%0d want=58", cs_rise - cs_fall); end
    total++; if (rises - r0 != 14) begin bad++; $display("FAIL single_sclk_rises got=%0d want=14", rises - r0); end
  endtask

  task automatic test_continuous();
    frame_t f[3];
    int n0, s0, e0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < CH; c++) f[k][c] = TOT'('h100 + k*CH + c) << SHR;
      frame_q.push_back(f[k]);
    end
    n0 = vq.size(); s0 = started_q.size();
    @(negedge clk) cont_en = 1'b1;
    @(posedge clk); #1 e0 = cyc;
    while (cyc < e0 + 124 + 20) @(negedge clk);
    cont_en = 1'b0;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin bad++; $display("FAIL cont_idle busy=%b cs_n=%b want=0,1", busy, cs_n); end
    total++; if (started_q.size() - s0 != 3) begin bad++; $display("FAIL cont_frames got=%0d want=3", started_q.size() - s0); end
    total++; if (vq.size() - n0 != 3) begin bad++; $display("FAIL cont_count got=%0d want=3", vq.size() - n0); end
    if (vq.size() - n0 >= 3) begin
      total++; if (vc[n0] != e0 + 59) begin bad++; $display("FAIL cont_first_time got=%0d want=59", vc[n0] - e0); end
      for (int k = 0; k < 3; k++) begin
        total++; if (vq[n0+k] !== model(f[k])) begin bad++; $display("FAIL cont_data%0d got=%h want=%h", k, vq[n0+k], model(f[k])); end
        if (k > 0) begin
          total++; if (vc[n0+k] - vc[n0+k-1] != 62) begin bad++; $display("FAIL cont_period%0d got=%0d want=62", k, vc[n0+k] - vc[n0+k-1]); end
        end
      end
    end
  endtask

  task automatic test_overrun();
    frame_t f = rand_frame();
    int n0, o0, s0, e0;
    frame_q.push_back(f);
    n0 = vq.size(); o0 = oc.size(); s0 = started_q.size();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 e0 = cyc; start = 1'b0;
    while (cyc < e0 + 9) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++; if (oc.size() - o0 != 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", oc.size() - o0); end
    if (oc.size() > o0) begin
      total++; if (oc[o0] != e0 + 10) begin bad++; $display("FAIL ovr_time got=%0d want=10", oc[o0] - e0); end
    end
    total++; if (started_q.size() - s0 != 1 || vq.size() - n0 != 1) begin bad++; $display("FAIL ovr_frames frames=%0d valids=%0d want=1,1", started_q.size() - s0, vq.size() - n0); end
    if (vq.size() > n0) begin
      total++; if (vq[n0] !== model(f)) begin bad++; $display("FAIL ovr_data got=%h want=%h", vq[n0], model(f)); end
    end
  endtask

  task automatic test_reset_abort();
    frame_t f;
    int n0, e0;
    frame_q.push_back(rand_frame());
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 e0 = cyc; start = 1'b0;
    while (cyc < e0 + 30) @(negedge clk);
    reset_b = 1'b0;
    #1;
    total++; if ({cs_n, sclk, busy} !== 3'b100) begin bad++; $display("FAIL abort_async got=%b want=100", {cs_n, sclk, busy}); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL abort_data got=%h want=0", data_out); end
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    n0 = vq.size();
    repeat (80) @(negedge clk);
    total++; if (vq.size() != n0 || cs_n !== 1'b1) begin bad++; $display("FAIL abort_no_valid got=%0d cs_n=%b want=0,1", vq.size() - n0, cs_n); end
    f = rand_frame();
    frame_q.push_back(f);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (vq.size() - n0 != 1) begin bad++; $display("FAIL abort_restart_count got=%0d want=1", vq.size() - n0); end
    if (vq.size() > n0) begin
      total++; if (vq[n0] !== model(f)) begin bad++; $display("FAIL abort_restart_data got=%h want=%h", vq[n0], model(f)); end
    end
  endtask

  task automatic test_params();
    int n0, e0;
    frame2 = {4'($urandom), 12'hABC};
    n0 = vq2.size();
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1 e0 = cyc; start2 = 1'b0;
    for (int k = 0; k < 100 && busy2; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++; if (vq2.size() - n0 != 1) begin bad++; $display("FAIL param_count got=%0d want=1", vq2.size() - n0); end
    if (vq2.size() > n0) begin
      total++; if (vq2[n0] !== 12'hABC) begin bad++; $display("FAIL param_data got=%h want=abc", vq2[n0]); end
      total++; if (vc2[n0] != e0 + 34) begin bad++; $display("FAIL param_time got=%0d want=34", vc2[n0] - e0); end
    end
    total++; if (data_out2 !== 12'hABC) begin bad++; $display("FAIL param_hold got=%h want=abc", data_out2); end
  endtask

  task automatic test_random();
    int n0, s0, nf, nv;
    n0 = vq.size(); s0 = started_q.size();
    @(negedge clk) cont_en = 1'b1;
    for (int k = 0; k < 200*62 + 200 && started_q.size() - s0 < 200; k++) @(negedge clk);
    cont_en = 1'b0;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    nf = started_q.size() - s0;
    nv = vq.size() - n0;
    total++; if (nf != 200 || nv != 200) begin bad++; $display("FAIL rand_counts frames=%0d valids=%0d want=200", nf, nv); end
    for (int i = 0; i < nf && i < nv; i++) begin
      total++;
      if (vq[n0+i] !== model(started_q[s0+i])) begin
        bad++; $display("FAIL rand_data%0d got=%h want=%h", i, vq[n0+i], model(started_q[s0+i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_overrun();
    test_reset_abort();
    test_params();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
